vgpr_paged_rf_3r_2w: RTL and testbench
======================================

# vgpr_paged_rf_3r_2w

Parametrised, paged vector register file for the SIMD/SIMF vector pipeline: PAGES independent lanes (one per work-item), each DEPTH x WIDTH, with three registered read ports and two masked write ports. It is the configurable successor of the fixed 64-page 1024x32b file. It adds synchronous read latency, defined write-write priority, optional write-to-read forwarding, and a post-reset scrub engine that zeroes every entry before accepting traffic.

## Interface
- PAGES, 64, number of lanes/pages
- DEPTH, 1024, registers per page (power of two)
- AW, 10, address width = log2(DEPTH)
- WIDTH, 32, register width in bits
- GROUP, 4, consecutive registers accessed by rd0/wr1 per page (power of two, <= DEPTH)

Ports:
- clk  input  1  clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- init_busy  output  1  high while scrub engine runs
- rd0_addr  input  AW  group read address; low log2(GROUP) bits ignored
- rd0_data  output  PAGES*GROUP*WIDTH  page p, reg g at bits [(p*GROUP+g)*WIDTH +: WIDTH]
- rd1_addr, rd2_addr  input  AW  single-register read addresses
- rd1_data, rd2_data  output  PAGES*WIDTH  page p at [p*WIDTH +: WIDTH]
- wr0_en  input  PAGES  per-page write enable, port 0
- wr0_addr  input  AW  port-0 write address
- wr0_data  input  PAGES*WIDTH  port-0 write data
- wr1_en  input  PAGES  per-page write enable, port 1
- wr1_grp_en  input  GROUP  per-register mask within the group (shared by all pages)
- wr1_addr  input  AW  group write address; low log2(GROUP) bits ignored
- wr1_data  input  PAGES*GROUP*WIDTH  layout as rd0_data

## Operation
- Effective port-1 enable for page p, reg g = wr1_en[p] & wr1_grp_en[g]. Target address = {wr1_addr[AW-1:log2 GROUP], g}.
- FSM states: SCRUB, READY. rst forces SCRUB with scrub counter = 0.
- SCRUB: each cycle, write 0 to row counter in all pages. Increment the counter. After row DEPTH-1 is written, go to READY. init_busy=1. wr0/wr1 are ignored, and all read outputs are held at 0.
- READY: init_busy=0. Writes and reads are serviced every cycle. No stalls and no backpressure.
- Write conflict: when both ports target the same page and address in the same cycle, wr0 wins and the wr1 data for that register is dropped. Other registers in the wr1 group are still written.
- Reads are independent. Any port may alias any other port or address.
- Read/write same cycle, same address: behaviour set by Configuration.

## Timing
- Reset values: init_busy=1, rd0_data/rd1_data/rd2_data=0, FSM=SCRUB, counter=0.
- Scrub duration: exactly DEPTH cycles after rst deasserts. init_busy falls on the edge that completes row DEPTH-1. The first write is accepted in the following cycle.
- Read latency: 1 cycle. The address is sampled at edge N, and data is valid after edge N and held until the next edge.
- Write latency: data written at edge N is visible to a read issued at edge N+1 (returned after N+1).
- rst asserted mid-scrub or mid-traffic: outputs clear immediately and scrub restarts from row 0. Array contents are not relied on until the scrub completes.

## Configuration
- VGPR_RF_BYPASS_EN defined: write-first forwarding. A read sampled at edge N to an address being written at edge N returns the new data. Forwarding honours per-page and per-group enables and wr0 priority. Unwritten lanes return stored data.
- Undefined: read-first. Same-cycle reads return the old contents. Required for pure block-RAM mapping on FPGA_BUILD.

## Test plan
- Scrub: write garbage via backdoor, pulse rst. Check init_busy=1 for exactly 1024 cycles, then a read of addr 0x3FF on all ports returns all-zero.
- Basic R/W: wr0_en=all ones, addr 5, page p data=p+0x100. Next cycle rd1_addr=5 -> page p returns p+0x100 one cycle later.
- Group mask: wr1_addr=0x0A (treated as 0x08), wr1_en[3]=1 only, wr1_grp_en=4'b0101, data 0xA5A5_0000+g. rd0_addr=0x08 -> page 3 regs 0 and 2 are updated, regs 1 and 3 and all other pages unchanged.
- Conflict: wr0 addr 0x10 data 0x1111 and wr1 group 0x10 data 0x2222, all pages. Reg 0x10 reads 0x1111 and regs 0x11-0x13 read 0x2222.
- Same-cycle RAW at addr 7 (old 0x0, new 0xDEAD): returns 0xDEAD with VGPR_RF_BYPASS_EN, 0x0 without.
- rst at scrub cycle 500 and at steady traffic: outputs go 0 asynchronously, and init_busy stays high for a full 1024 cycles after release.

Source files
------------

// File: rtl/vgpr_paged_rf_3r_2w.sv
// Paged vector register file: PAGES lanes of DEPTH x WIDTH, 3 registered read ports, 2 masked write ports.
// Post-reset scrub zeroes every row; define VGPR_RF_BYPASS_EN for write-first forwarding (default read-first).
module vgpr_paged_rf_3r_2w #(
  parameter int unsigned PAGES = 64,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GROUP = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           init_busy,
  input  logic [AW-1:0]                  rd0_addr,
  output logic [PAGES*GROUP*WIDTH-1:0]   rd0_data,
  input  logic [AW-1:0]                  rd1_addr,
  output logic [PAGES*WIDTH-1:0]         rd1_data,
  input  logic [AW-1:0]                  rd2_addr,
  output logic [PAGES*WIDTH-1:0]         rd2_data,
  input  logic [PAGES-1:0]               wr0_en,
  input  logic [AW-1:0]                  wr0_addr,
  input  logic [PAGES*WIDTH-1:0]         wr0_data,
  input  logic [PAGES-1:0]               wr1_en,
  input  logic [GROUP-1:0]               wr1_grp_en,
  input  logic [AW-1:0]                  wr1_addr,
  input  logic [PAGES*GROUP*WIDTH-1:0]   wr1_data
);

  localparam logic [AW-1:0] GMASK = AW'(GROUP - 1);

  typedef enum logic {SCRUB, READY} state_t;

  state_t                         state_q, state_d;
  logic [AW-1:0]                  cnt_q, cnt_d;
  logic [WIDTH-1:0]               mem [PAGES][DEPTH];
  logic [PAGES-1:0][GROUP-1:0]    wr1_we;
  logic [AW-1:0]                  wr1_base, rd0_base;
  logic [AW-1:0]                  rs_addr [2];
  logic [PAGES*GROUP*WIDTH-1:0]   rd0_nx;
  logic [1:0][PAGES*WIDTH-1:0]    rs_nx;

  assign wr1_base   = wr1_addr & ~GMASK;
  assign rd0_base   = rd0_addr & ~GMASK;
  assign rs_addr[0] = rd1_addr;
  assign rs_addr[1] = rd2_addr;
  assign init_busy  = (state_q == SCRUB);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      SCRUB: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) state_d = READY;
      end
      READY: ;
      default: state_d = SCRUB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SCRUB;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Port-1 lanes that collide with a port-0 write are masked here, so wr0 priority
  // does not depend on assignment order in the array process.
  always_comb begin
    wr1_we = '0;
    for (int unsigned p = 0; p < PAGES; p++) begin
      for (int unsigned g = 0; g < GROUP; g++) begin
        wr1_we[p][g] = wr1_en[p] & wr1_grp_en[g]
                     & ~(wr0_en[p] & (wr0_addr == (wr1_base | AW'(g))));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == SCRUB) begin
      for (int unsigned p = 0; p < PAGES; p++) mem[p][cnt_q] <= '0;
    end else begin
      for (int unsigned p = 0; p < PAGES; p++) begin
        for (int unsigned g = 0; g < GROUP; g++) begin
          if (wr1_we[p][g])
            mem[p][wr1_base | AW'(g)] <= wr1_data[(p*GROUP+g)*WIDTH +: WIDTH];
        end
        if (wr0_en[p]) mem[p][wr0_addr] <= wr0_data[p*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
`ifdef VGPR_RF_BYPASS_EN
    int unsigned gi;
`endif
    rd0_nx = '0;
    rs_nx  = '0;
    for (int unsigned p = 0; p < PAGES; p++) begin
      for (int unsigned g = 0; g < GROUP; g++) begin
        rd0_nx[(p*GROUP+g)*WIDTH +: WIDTH] = mem[p][rd0_base | AW'(g)];
`ifdef VGPR_RF_BYPASS_EN
        if (wr1_we[p][g] && (wr1_base == rd0_base))
          rd0_nx[(p*GROUP+g)*WIDTH +: WIDTH] = wr1_data[(p*GROUP+g)*WIDTH +: WIDTH];
        if (wr0_en[p] && (wr0_addr == (rd0_base | AW'(g))))
          rd0_nx[(p*GROUP+g)*WIDTH +: WIDTH] = wr0_data[p*WIDTH +: WIDTH];
`endif
      end
      for (int unsigned s = 0; s < 2; s++) begin
        rs_nx[s][p*WIDTH +: WIDTH] = mem[p][rs_addr[s]];
`ifdef VGPR_RF_BYPASS_EN
        gi = 32'(rs_addr[s] & GMASK);
        if (wr1_we[p][gi] && ((rs_addr[s] & ~GMASK) == wr1_base))
          rs_nx[s][p*WIDTH +: WIDTH] = wr1_data[(p*GROUP+gi)*WIDTH +: WIDTH];
        if (wr0_en[p] && (wr0_addr == rs_addr[s]))
          rs_nx[s][p*WIDTH +: WIDTH] = wr0_data[p*WIDTH +: WIDTH];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd0_data <= '0;
      rd1_data <= '0;
      rd2_data <= '0;
    end else if (state_q == SCRUB) begin
      rd0_data <= '0;
      rd1_data <= '0;
      rd2_data <= '0;
    end else begin
      rd0_data <= rd0_nx;
      rd1_data <= rs_nx[0];
      rd2_data <= rs_nx[1];
    end
  end

endmodule

// File: tb/tb_vgpr_paged_rf_3r_2w.sv
// Directed, table-driven bench for vgpr_paged_rf_3r_2w: scrub timing, R/W, group masks,
// write priority, same-cycle RAW (mode follows VGPR_RF_BYPASS_EN) and async reset.
module tb_vgpr_paged_rf_3r_2w;

  localparam int unsigned P  = 64;
  localparam int unsigned D  = 1024;
  localparam int unsigned AW = 10;
  localparam int unsigned W  = 32;
  localparam int unsigned G  = 4;

`ifdef VGPR_RF_BYPASS_EN
  localparam logic [W-1:0] RAW_A = 32'hDEAD;
  localparam logic [W-1:0] RAW_B = 32'hBEEF;
`else
  localparam logic [W-1:0] RAW_A = 32'h0;
  localparam logic [W-1:0] RAW_B = 32'h0;
`endif

  logic               clk, rst, init_busy;
  logic [AW-1:0]      rd0_addr, rd1_addr, rd2_addr, wr0_addr, wr1_addr;
  logic [P*G*W-1:0]   rd0_data, wr1_data;
  logic [P*W-1:0]     rd1_data, rd2_data, wr0_data;
  logic [P-1:0]       wr0_en, wr1_en;
  logic [G-1:0]       wr1_grp_en;

  vgpr_paged_rf_3r_2w #(.PAGES(P), .DEPTH(D), .AW(AW), .WIDTH(W), .GROUP(G)) dut (
    .clk(clk), .rst(rst), .init_busy(init_busy),
    .rd0_addr(rd0_addr), .rd0_data(rd0_data),
    .rd1_addr(rd1_addr), .rd1_data(rd1_data),
    .rd2_addr(rd2_addr), .rd2_data(rd2_data),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_grp_en(wr1_grp_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [P-1:0]   w0_en;
    logic [AW-1:0]  w0_addr;
    logic [W-1:0]   w0_base;
    logic [P-1:0]   w1_en;
    logic [G-1:0]   w1_grp;
    logic [AW-1:0]  w1_addr;
    logic [W-1:0]   w1_base;
    logic [W-1:0]   w1_gstep;
    logic [AW-1:0]  r0, r1, r2;
    int unsigned    pg;
    logic [G*W-1:0] e0;
    logic [W-1:0]   e1, e2;
  } vec_t;

  vec_t vt [8];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic [P-1:0] w0e, logic [AW-1:0] w0a, logic [W-1:0] w0b,
                              logic [P-1:0] w1e, logic [G-1:0] w1g, logic [AW-1:0] w1a,
                              logic [W-1:0] w1b, logic [W-1:0] w1s,
                              logic [AW-1:0] r0, logic [AW-1:0] r1, logic [AW-1:0] r2,
                              int unsigned pg, logic [G*W-1:0] e0, logic [W-1:0] e1,
                              logic [W-1:0] e2);
    vec_t v;
    v.w0_en = w0e; v.w0_addr = w0a; v.w0_base = w0b;
    v.w1_en = w1e; v.w1_grp = w1g; v.w1_addr = w1a; v.w1_base = w1b; v.w1_gstep = w1s;
    v.r0 = r0; v.r1 = r1; v.r2 = r2; v.pg = pg; v.e0 = e0; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] r0v(int unsigned p, int unsigned g);
    return rd0_data[(p*G+g)*W +: W];
  endfunction

  task automatic set_w0(input logic [P-1:0] en, input logic [AW-1:0] a,
                        input logic [W-1:0] base, input logic [W-1:0] pstep);
    wr0_en = en; wr0_addr = a;
    for (int unsigned p = 0; p < P; p++) wr0_data[p*W +: W] = base + W'(p) * pstep;
  endtask

  task automatic set_w1(input logic [P-1:0] en, input logic [G-1:0] grp, input logic [AW-1:0] a,
                        input logic [W-1:0] base, input logic [W-1:0] gstep);
    wr1_en = en; wr1_grp_en = grp; wr1_addr = a;
    for (int unsigned p = 0; p < P; p++)
      for (int unsigned g = 0; g < G; g++) wr1_data[(p*G+g)*W +: W] = base + W'(g) * gstep;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (init_busy && n < 3000) begin
      tick;
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    // Group fields {reg3, reg2, reg1, reg0}
    vt[0] = mk('1, 10'h005, 32'h100, '0, 4'b0000, 10'h0, 32'h0, 32'h0,
               10'h004, 10'h005, 10'h005, 7, {32'h0, 32'h0, 32'h107, 32'h0}, 32'h107, 32'h107);
    vt[1] = mk('0, 10'h0, 32'h0, '0, 4'b0000, 10'h0, 32'h0, 32'h0,
               10'h006, 10'h005, 10'h004, 0, {32'h0, 32'h0, 32'h100, 32'h0}, 32'h100, 32'h0);
    vt[2] = mk('0, 10'h0, 32'h0, 64'h8, 4'b0101, 10'h00A, 32'hA5A5_0000, 32'h1,
               10'h008, 10'h008, 10'h00A, 3, {32'h0, 32'hA5A5_0002, 32'h0, 32'hA5A5_0000},
               32'hA5A5_0000, 32'hA5A5_0002);
    vt[3] = mk('0, 10'h0, 32'h0, '0, 4'b0000, 10'h0, 32'h0, 32'h0,
               10'h008, 10'h00A, 10'h009, 2, {32'h0, 32'h0, 32'h0, 32'h0}, 32'h0, 32'h0);
    vt[4] = mk('0, 10'h0, 32'h0, '0, 4'b0000, 10'h0, 32'h0, 32'h0,
               10'h00B, 10'h009, 10'h00B, 3, {32'h0, 32'hA5A5_0002, 32'h0, 32'hA5A5_0000},
               32'h0, 32'h0);
    vt[5] = mk('1, 10'h010, 32'h1111, '1, 4'b1111, 10'h010, 32'h2222, 32'h0,
               10'h010, 10'h010, 10'h013, 0, {32'h2222, 32'h2222, 32'h2222, 32'h1111},
               32'h1111, 32'h2222);
    vt[6] = mk('0, 10'h0, 32'h0, '0, 4'b0000, 10'h0, 32'h0, 32'h0,
               10'h012, 10'h010, 10'h011, 9, {32'h2222, 32'h2222, 32'h2222, 32'h111A},
               32'h111A, 32'h2222);
    vt[7] = mk(64'h200, 10'h011, 32'h3000, 64'h200, 4'b1000, 10'h010, 32'h4444, 32'h0,
               10'h010, 10'h011, 10'h013, 9, {32'h4444, 32'h2222, 32'h3009, 32'h111A},
               32'h3009, 32'h4444);

    rst = 1'b1;
    set_w0('0, '0, '0, '0);
    set_w1('0, '0, '0, '0, '0);
    rd0_addr = '0; rd1_addr = '0; rd2_addr = '0;
    #2;
    chk("reset init_busy", 64'(init_busy), 64'h1);
    chk("reset rd0 nonzero", 64'(|rd0_data), 64'h0);
    chk("reset rd1 nonzero", 64'(|rd1_data), 64'h0);
    chk("reset rd2 nonzero", 64'(|rd2_data), 64'h0);
    tick;
    rst = 1'b0;
    wait_ready(n);
    chk("initial scrub cycles", 64'(n), 64'd1024);

    for (int i = 0; i < 8; i++) begin
      set_w0(vt[i].w0_en, vt[i].w0_addr, vt[i].w0_base, 32'h1);
      set_w1(vt[i].w1_en, vt[i].w1_grp, vt[i].w1_addr, vt[i].w1_base, vt[i].w1_gstep);
      tick;
      set_w0('0, '0, '0, '0);
      set_w1('0, '0, '0, '0, '0);
      rd0_addr = vt[i].r0; rd1_addr = vt[i].r1; rd2_addr = vt[i].r2;
      tick;
      for (int unsigned g = 0; g < G; g++)
        chk($sformatf("vec%0d rd0 pg%0d reg%0d", i, vt[i].pg, g),
            64'(r0v(vt[i].pg, g)), 64'(vt[i].e0[g*W +: W]));
      chk($sformatf("vec%0d rd1 pg%0d", i, vt[i].pg), 64'(rd1_data[vt[i].pg*W +: W]), 64'(vt[i].e1));
      chk($sformatf("vec%0d rd2 pg%0d", i, vt[i].pg), 64'(rd2_data[vt[i].pg*W +: W]), 64'(vt[i].e2));
    end

    // Same-cycle read and write: wr0 to addr 7 on all pages, wr1 to 0x20 on page 1 reg 0 only
    set_w0('1, 10'h007, 32'hDEAD, 32'h0);
    set_w1(64'h2, 4'b0001, 10'h020, 32'hBEEF, 32'h0);
    rd0_addr = 10'h004; rd1_addr = 10'h007; rd2_addr = 10'h020;
    tick;
    chk("raw rd1 pg2", 64'(rd1_data[2*W +: W]), 64'(RAW_A));
    chk("raw rd0 pg2 reg3", 64'(r0v(2, 3)), 64'(RAW_A));
    chk("raw rd0 pg2 reg1", 64'(r0v(2, 1)), 64'h102);
    chk("raw rd2 pg1", 64'(rd2_data[1*W +: W]), 64'(RAW_B));
    chk("raw rd2 pg0 unwritten", 64'(rd2_data[0 +: W]), 64'h0);
    set_w0('0, '0, '0, '0);
    set_w1('0, '0, '0, '0, '0);
    tick;
    chk("after raw rd1 pg2", 64'(rd1_data[2*W +: W]), 64'hDEAD);
    chk("after raw rd2 pg1", 64'(rd2_data[1*W +: W]), 64'hBEEF);
    chk("after raw rd2 pg0", 64'(rd2_data[0 +: W]), 64'h0);

    // Asynchronous reset during traffic
    #2;
    rst = 1'b1;
    #1;
    chk("mid-traffic rst rd1 nonzero", 64'(|rd1_data), 64'h0);
    chk("mid-traffic rst rd0 nonzero", 64'(|rd0_data), 64'h0);
    chk("mid-traffic rst init_busy", 64'(init_busy), 64'h1);
    tick;
    rst = 1'b0;
    wait_ready(n);
    chk("traffic-rst scrub cycles", 64'(n), 64'd1024);

    // First write right after scrub completes
    set_w0('1, 10'h3FF, 32'hC0DE_0000, 32'h1);
    tick;
    set_w0('0, '0, '0, '0);
    rd0_addr = 10'h3FC; rd1_addr = 10'h3FF; rd2_addr = 10'h3FF;
    tick;
    chk("first write rd1 pg5", 64'(rd1_data[5*W +: W]), 64'hC0DE_0005);
    chk("first write rd0 pg63 reg3", 64'(r0v(63, 3)), 64'hC0DE_003F);

    // Scrub clears stale data; writes presented during scrub are ignored
    rst = 1'b1;
    set_w0('1, 10'h000, 32'h5555, 32'h0);
    tick;
    rst = 1'b0;
    repeat (10) tick;
    chk("scrub rd1 held zero", 64'(|rd1_data), 64'h0);
    chk("scrub init_busy", 64'(init_busy), 64'h1);
    wait_ready(n);
    set_w0('0, '0, '0, '0);
    chk("scrub cycles", 64'(n + 10), 64'd1024);
    rd0_addr = 10'h3FF; rd1_addr = 10'h3FF; rd2_addr = 10'h000;
    tick;
    chk("post-scrub rd0 nonzero", 64'(|rd0_data), 64'h0);
    chk("post-scrub rd1 nonzero", 64'(|rd1_data), 64'h0);
    chk("post-scrub rd2 addr0 nonzero", 64'(|rd2_data), 64'h0);

    // Reset at scrub row 500
    rst = 1'b1;
    tick;
    rst = 1'b0;
    repeat (500) tick;
    #2;
    rst = 1'b1;
    #1;
    chk("mid-scrub rst init_busy", 64'(init_busy), 64'h1);
    chk("mid-scrub rst rd1 nonzero", 64'(|rd1_data), 64'h0);
    tick;
    rst = 1'b0;
    wait_ready(n);
    chk("mid-scrub rst scrub cycles", 64'(n), 64'd1024);
    set_w0('1, 10'h021, 32'h7700, 32'h1);
    tick;
    set_w0('0, '0, '0, '0);
    rd1_addr = 10'h021;
    tick;
    chk("after mid-scrub rst write pg10", 64'(rd1_data[10*W +: W]), 64'h770A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
